// File: rtl/phase_pkg.sv
// Shared definitions for the two-phase clock interface: monitor FSM state
// encoding and sticky fault bit positions.
package phase_pkg;

    typedef logic [2:0] state_t;

    localparam state_t HUNT  = 3'd0;
    localparam state_t P0_HI = 3'd1;
    localparam state_t GAP01 = 3'd2;
    localparam state_t P1_HI = 3'd3;
    localparam state_t GAP10 = 3'd4;

    localparam int FLT_OVERLAP = 0;
    localparam int FLT_NOGAP   = 1;
    localparam int FLT_ORDER   = 2;
    localparam int FLT_TIMEOUT = 3;
    localparam int FLT_W       = 4;

endpackage

// File: rtl/phase_monitor_sat_counter.sv
// W-bit up-counter that sticks at all-ones; synchronous clear has priority.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/phase_monitor.sv
// Receiver-side checker for the two-phase non-overlapping clock: tracks the
// P0 -> gap -> P1 -> gap sequence, measures its period and reports lock/faults.
module phase_monitor
    import phase_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int LOCK_CYCLES = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [1:0]       phase_in,
    input  logic             fault_clr,
    output logic             locked,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic [FLT_W-1:0] fault,
    output logic             fault_any
);

    localparam int MW = $clog2(LOCK_CYCLES + 1);
    localparam logic [MW-1:0] LOCK_M = MW'(LOCK_CYCLES);
    // state_cnt is 0 after the entry edge, so this is the TIMEOUT-th sample held in a state
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 2);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] state_cnt, period_cnt, period_new;
    logic [MW-1:0]    match_cnt, match_nxt;
    logic [FLT_W-1:0] new_flt, fault_nxt;
    logic             period_done, stay;
    logic             state_clr, period_clr;

    always_comb begin
        state_nxt   = state;
        new_flt     = '0;
        period_done = 1'b0;
        if (!enable) begin
            state_nxt = HUNT;
        end else begin
            case (state)
                HUNT: if (phase_in == 2'b01) state_nxt = P0_HI;
                P0_HI: case (phase_in)
                    2'b01: state_nxt = P0_HI;
                    2'b00: state_nxt = GAP01;
                    2'b11: begin new_flt[FLT_OVERLAP] = 1'b1; state_nxt = HUNT; end
                    default: begin new_flt[FLT_NOGAP] = 1'b1; state_nxt = HUNT; end
                endcase
                GAP01: case (phase_in)
                    2'b00: state_nxt = GAP01;
                    2'b10: state_nxt = P1_HI;
                    2'b01: begin new_flt[FLT_ORDER] = 1'b1; state_nxt = HUNT; end
                    default: begin new_flt[FLT_OVERLAP] = 1'b1; state_nxt = HUNT; end
                endcase
                P1_HI: case (phase_in)
                    2'b10: state_nxt = P1_HI;
                    2'b00: state_nxt = GAP10;
                    2'b11: begin new_flt[FLT_OVERLAP] = 1'b1; state_nxt = HUNT; end
                    default: begin new_flt[FLT_NOGAP] = 1'b1; state_nxt = HUNT; end
                endcase
                GAP10: case (phase_in)
                    2'b00: state_nxt = GAP10;
                    2'b01: begin state_nxt = P0_HI; period_done = 1'b1; end
                    2'b10: begin new_flt[FLT_ORDER] = 1'b1; state_nxt = HUNT; end
                    default: begin new_flt[FLT_OVERLAP] = 1'b1; state_nxt = HUNT; end
                endcase
                default: state_nxt = HUNT;
            endcase
        end

        stay = enable && (state != HUNT) && (state_nxt == state);
        if (stay && (state_cnt == TO_LAST)) begin
            new_flt[FLT_TIMEOUT] = 1'b1;
            state_nxt            = HUNT;
        end

        state_clr  = (state_nxt != state) || (state == HUNT);
        period_clr = ((state_nxt == P0_HI) && (state != P0_HI)) || (state_nxt == HUNT);

        // period_cnt is cleared on the rise edge itself, hence the +1
        period_new = (period_cnt == '1) ? period_cnt : period_cnt + 1'b1;

        if ((match_cnt == '0) || (period_new != period)) begin
            match_nxt = MW'(1);
        end else if (match_cnt != LOCK_M) begin
            match_nxt = match_cnt + 1'b1;
        end else begin
            match_nxt = match_cnt;
        end

        fault_nxt = (fault_clr ? '0 : fault) | new_flt;
    end

    sat_counter #(.W(CNT_W)) u_state_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_clr),
        .inc   (1'b1),
        .count (state_cnt)
    );

    sat_counter #(.W(CNT_W)) u_period_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (period_clr),
        .inc   (1'b1),
        .count (period_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= HUNT;
            locked       <= 1'b0;
            match_cnt    <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            fault        <= '0;
            fault_any    <= 1'b0;
        end else begin
            state        <= state_nxt;
            period_valid <= period_done;
            fault        <= fault_nxt;
            fault_any    <= |fault_nxt;
            if (state_nxt == HUNT) begin
                locked    <= 1'b0;
                match_cnt <= '0;
            end else if (period_done) begin
                period    <= period_new;
                match_cnt <= match_nxt;
                locked    <= (match_nxt >= LOCK_M);
            end
        end
    end

endmodule
